// File: rtl/isa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | isa_pkg : shared ISA constants, opcodes and fetch state encoding      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package isa_pkg;

    localparam int PC_W   = 9;
    localparam int INST_W = 20;
    localparam int OFF_W  = 15;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] OP_BE   = 5'b00111;
    localparam logic [OP_W-1:0] OP_BL   = 5'b01000;
    localparam logic [OP_W-1:0] OP_BG   = 5'b01001;
    localparam logic [OP_W-1:0] OP_BA   = 5'b01010;
    localparam logic [OP_W-1:0] OP_DONE = 5'b01110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // The result is truncated to PC_W bits, so sign-extending the offset is
    // unnecessary: the low PC_W bits of the sum are identical either way.
    function automatic logic [PC_W-1:0] branch_target(
        input logic [PC_W-1:0]  pc,
        input logic [OFF_W-1:0] off
    );
        return PC_W'(OFF_W'(pc) + off);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_resolve : decodes the live instruction register for branches  |
// | and the done opcode. Rev 1.0                                          |
// +----------------------------------------------------------------------+
module branch_resolve
    import isa_pkg::*;
(
    input  logic [INST_W-1:0] ir,
    input  logic [PC_W-1:0]   ir_pc,
    input  logic              ir_valid,
    input  logic              flag_eq,
    input  logic              flag_lt,
    input  logic              flag_gt,
    output logic              taken,
    output logic              is_done,
    output logic [PC_W-1:0]   target
);

    logic [OP_W-1:0] opcode;
    logic            cond;

    assign opcode = ir[INST_W-1 -: OP_W];
    assign target = branch_target(ir_pc, ir[OFF_W-1:0]);

    always_comb begin
        cond = 1'b0;
        case (opcode)
            OP_BE:   cond = flag_eq;
            OP_BL:   cond = flag_lt;
            OP_BG:   cond = flag_gt;
            OP_BA:   cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    // A squashed word must never redirect or halt the program.
    assign taken   = ir_valid & cond;
    assign is_done = ir_valid & (opcode == OP_DONE);

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_ctrl : instruction fetch sequencer with branch resolution and  |
// | program start/halt handshake. Rev 1.0                                 |
// +----------------------------------------------------------------------+
module fetch_ctrl
    import isa_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PC_W-1:0]   start_addr,
    input  logic              stall,
    input  logic [INST_W-1:0] inst,
    input  logic              flag_eq,
    input  logic              flag_lt,
    input  logic              flag_gt,
    output logic [PC_W-1:0]   iptr,
    output logic [INST_W-1:0] ir,
    output logic              ir_valid,
    output logic [PC_W-1:0]   ir_pc,
    output logic              busy,
    output logic              done
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic            taken;
    logic            is_done;
    logic [PC_W-1:0] target;

    assign iptr = pc;

    branch_resolve u_branch_resolve (
        .ir       (ir),
        .ir_pc    (ir_pc),
        .ir_valid (ir_valid),
        .flag_eq  (flag_eq),
        .flag_lt  (flag_lt),
        .flag_gt  (flag_gt),
        .taken    (taken),
        .is_done  (is_done),
        .target   (target)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state    <= RUN;
                        pc       <= start_addr;
                        ir_valid <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (is_done) begin
                            state    <= HALT;
                            ir_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            // On a taken branch the word fetched now is the
                            // wrong path: load it but mark it dead.
                            ir       <= inst;
                            ir_pc    <= pc;
                            ir_valid <= ~taken;
                            pc       <= taken ? target : pc + PC_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    ir_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_ctrl : directed and randomized checks against a program-    |
// | level reference model. Rev 1.0                                        |
// +----------------------------------------------------------------------+
module tb_fetch_ctrl;
    import isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start, stall, flag_eq, flag_lt, flag_gt;
    logic [8:0]  start_addr, iptr, ir_pc;
    logic [19:0] inst, ir;
    logic        ir_valid, busy, done;

    logic [19:0] rom [0:511];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [8:0]  m_pc, m_ir_pc;
    logic [19:0] m_ir;
    logic        m_valid, m_busy, m_done;

    assign inst = rom[iptr];
    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .stall      (stall),
        .inst       (inst),
        .flag_eq    (flag_eq),
        .flag_lt    (flag_lt),
        .flag_gt    (flag_gt),
        .iptr       (iptr),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .ir_pc      (ir_pc),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [19:0] nop_word();
        logic [4:0] op;
        op = 5'($urandom_range(0, 6));
        return {op, 15'($urandom)};
    endfunction

    task automatic fill_rom();
        for (int i = 1; i < 512; i++) rom[i] = nop_word();
        rom[0] = {OP_DONE, 15'd0};
    endtask

    // Program-level rules: what the machine does with the word it holds.
    task automatic model_update();
        logic [4:0]  op;
        logic [14:0] offb;
        int          off, nx;
        bit          tk;
        if (!rst_n) begin
            m_pc = 0; m_ir = 0; m_ir_pc = 0; m_valid = 0; m_busy = 0; m_done = 0;
        end else if (start && !m_busy) begin
            m_pc = start_addr; m_valid = 0; m_done = 0; m_busy = 1;
        end else if (m_busy && !stall) begin
            op   = m_ir[19:15];
            offb = m_ir[14:0];
            tk   = m_valid && ((op == OP_BE && flag_eq) || (op == OP_BL && flag_lt) ||
                               (op == OP_BG && flag_gt) || (op == OP_BA));
            if (m_valid && op == OP_DONE) begin
                m_busy = 0; m_done = 1; m_valid = 0;
            end else begin
                off = int'(offb);
                if (off >= 16384) off -= 32768;
                nx = (int'(m_ir_pc) + off) % 512;
                if (nx < 0) nx += 512;
                m_ir    = rom[m_pc];
                m_ir_pc = m_pc;
                m_valid = !tk;
                m_pc    = tk ? 9'(nx) : 9'((int'(m_pc) + 1) % 512);
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_at(input logic [8:0] a);
        rst_n = 0; start = 0; stall = 0;
        step();
        rst_n = 1; start = 1; start_addr = a;
        step();
        start = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; stall = 0;
        repeat (2) step();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({iptr, ir_valid, busy, done} !== {9'd0, 3'b000}) begin
                miscompares++;
                $display("FAIL reset k=%0d iptr=%0d valid=%0b busy=%0b done=%0b required 0 0 0 0",
                         k, iptr, ir_valid, busy, done);
            end
            rst_n = 1;
            step();
        end
    endtask

    task automatic test_sequential();
        fill_rom();
        begin_at(9'd1);
        vectors++;
        if ({iptr, ir_valid, busy, done} !== {9'd1, 3'b010}) begin
            miscompares++;
            $display("FAIL seq_start iptr=%0d valid=%0b busy=%0b done=%0b required 1 0 1 0",
                     iptr, ir_valid, busy, done);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            vectors++;
            if (iptr !== 9'(k + 2) || ir_pc !== 9'(k + 1) || ir_valid !== 1'b1 || ir !== rom[k + 1]) begin
                miscompares++;
                $display("FAIL seq k=%0d iptr=%0d ir_pc=%0d valid=%0b ir=%h required %0d %0d 1 %h",
                         k, iptr, ir_pc, ir_valid, ir, k + 2, k + 1, rom[k + 1]);
            end
        end
    endtask

    task automatic test_branch_back();
        logic [8:0] e_iptr;
        fill_rom();
        rom[16] = {OP_BL, 15'h7FF2};
        for (int pass = 0; pass < 2; pass++) begin
            flag_eq = 1'($urandom); flag_gt = 1'($urandom); flag_lt = 0;
            begin_at(9'd14);
            repeat (3) step();
            vectors++;
            if (ir !== rom[16] || ir_pc !== 9'd16 || ir_valid !== 1'b1 || iptr !== 9'd17) begin
                miscompares++;
                $display("FAIL bl_setup ir=%h ir_pc=%0d valid=%0b iptr=%0d required bl 16 1 17",
                         ir, ir_pc, ir_valid, iptr);
            end
            flag_lt = (pass == 0);
            step();
            e_iptr = (pass == 0) ? 9'd2 : 9'd18;
            vectors++;
            if (iptr !== e_iptr || ir_valid !== (pass != 0)) begin
                miscompares++;
                $display("FAIL bl pass=%0d iptr=%0d valid=%0b required %0d %0b",
                         pass, iptr, ir_valid, e_iptr, pass != 0);
            end
            flag_lt = 0;
            step();
            vectors++;
            if (iptr !== e_iptr + 9'd1 || ir_pc !== e_iptr || ir_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bl_after pass=%0d iptr=%0d ir_pc=%0d valid=%0b required %0d %0d 1",
                         pass, iptr, ir_pc, ir_valid, e_iptr + 9'd1, e_iptr);
            end
        end
    endtask

    task automatic test_forward_be();
        logic [8:0] e_iptr;
        fill_rom();
        rom[5] = {OP_BE, 15'd4};
        for (int pass = 0; pass < 2; pass++) begin
            flag_lt = 1'($urandom); flag_gt = 1'($urandom); flag_eq = 0;
            begin_at(9'd3);
            repeat (3) step();
            flag_eq = (pass == 0);
            step();
            e_iptr = (pass == 0) ? 9'd9 : 9'd7;
            vectors++;
            if (iptr !== e_iptr || ir_valid !== (pass != 0)) begin
                miscompares++;
                $display("FAIL be pass=%0d iptr=%0d valid=%0b required %0d %0b",
                         pass, iptr, ir_valid, e_iptr, pass != 0);
            end
        end
        flag_eq = 0;
    endtask

    task automatic test_stall_branch();
        fill_rom();
        rom[10] = {OP_BA, 15'd20};
        begin_at(9'd8);
        repeat (3) step();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (iptr !== 9'd11 || ir_pc !== 9'd10 || ir !== rom[10] || ir_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall k=%0d iptr=%0d ir_pc=%0d ir=%h valid=%0b required 11 10 %h 1",
                         k, iptr, ir_pc, ir, ir_valid, rom[10]);
            end
        end
        stall = 0;
        step();
        vectors++;
        if (iptr !== 9'd30 || ir_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release iptr=%0d valid=%0b required 30 0", iptr, ir_valid);
        end
        step();
        vectors++;
        if (iptr !== 9'd31 || ir_pc !== 9'd30 || ir_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_after iptr=%0d ir_pc=%0d valid=%0b required 31 30 1",
                     iptr, ir_pc, ir_valid);
        end
    endtask

    task automatic test_done_restart();
        fill_rom();
        rom[20] = {OP_DONE, 15'h1234};
        begin_at(9'd18);
        repeat (3) step();
        for (int k = 0; k < 4; k++) begin
            stall = (k > 0) ? 1'($urandom) : 1'b0;
            step();
            vectors++;
            if ({done, busy, ir_valid} !== 3'b100 || iptr !== 9'd21) begin
                miscompares++;
                $display("FAIL halt k=%0d done=%0b busy=%0b valid=%0b iptr=%0d required 1 0 0 21",
                         k, done, busy, ir_valid, iptr);
            end
        end
        // start and stall together: start must win
        start = 1; start_addr = 9'd25; stall = 1;
        step();
        start = 0; stall = 0;
        vectors++;
        if ({done, busy, ir_valid} !== 3'b010 || iptr !== 9'd25) begin
            miscompares++;
            $display("FAIL restart done=%0b busy=%0b valid=%0b iptr=%0d required 0 1 0 25",
                     done, busy, ir_valid, iptr);
        end
        repeat (2) step();
        vectors++;
        if (iptr !== 9'd27 || ir_pc !== 9'd26 || ir_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_run iptr=%0d ir_pc=%0d valid=%0b required 27 26 1",
                     iptr, ir_pc, ir_valid);
        end
        // reset and start together: reset must win
        rst_n = 0; start = 1; start_addr = 9'd99;
        step();
        rst_n = 1; start = 0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({iptr, ir_pc, ir, ir_valid, busy, done} !== 41'd0) begin
                miscompares++;
                $display("FAIL midrun_reset k=%0d iptr=%0d ir_pc=%0d ir=%h valid=%0b busy=%0b done=%0b required all 0",
                         k, iptr, ir_pc, ir, ir_valid, busy, done);
            end
            step();
        end
    endtask

    task automatic test_wrap();
        fill_rom();
        begin_at(9'd510);
        repeat (2) step();
        vectors++;
        if (iptr !== 9'd0 || ir_pc !== 9'd511 || ir_valid !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap iptr=%0d ir_pc=%0d valid=%0b done=%0b required 0 511 1 0",
                     iptr, ir_pc, ir_valid, done);
        end
        repeat (2) step();
        vectors++;
        if ({done, busy, ir_valid} !== 3'b100 || iptr !== 9'd1 || ir_pc !== 9'd0) begin
            miscompares++;
            $display("FAIL wrap_halt done=%0b busy=%0b valid=%0b iptr=%0d ir_pc=%0d required 1 0 0 1 0",
                     done, busy, ir_valid, iptr, ir_pc);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 1; i < 512; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 68)      rom[i] = nop_word();
            else if (r < 96) rom[i] = {5'(OP_BE + 5'($urandom_range(0, 3))),
                                       (r < 90) ? 15'($urandom_range(0, 80) - 40) : 15'($urandom)};
            else             rom[i] = {OP_DONE, 15'($urandom)};
        end
        rom[0] = {OP_DONE, 15'd0};
        begin_at(9'($urandom));
        for (int c = 0; c < 3000; c++) begin
            flag_eq    = 1'($urandom);
            flag_lt    = 1'($urandom);
            flag_gt    = 1'($urandom);
            stall      = ($urandom_range(0, 4) == 0);
            start      = ($urandom_range(0, 29) == 0);
            start_addr = 9'($urandom);
            rst_n      = ($urandom_range(0, 299) != 0);
            step();
            vectors++;
            if ({iptr, ir_pc, ir_valid, busy, done} !== {m_pc, m_ir_pc, m_valid, m_busy, m_done} ||
                (m_valid && ir !== m_ir)) begin
                miscompares++;
                $display("FAIL rand c=%0d iptr=%0d ir_pc=%0d valid=%0b busy=%0b done=%0b ir=%h required %0d %0d %0b %0b %0b %h",
                         c, iptr, ir_pc, ir_valid, busy, done, ir,
                         m_pc, m_ir_pc, m_valid, m_busy, m_done, m_ir);
            end
        end
        start = 0; stall = 0; rst_n = 1;
    endtask

    initial begin
        rst_n = 0; start = 0; stall = 0; start_addr = '0;
        flag_eq = 0; flag_lt = 0; flag_gt = 0;
        m_pc = 0; m_ir = 0; m_ir_pc = 0; m_valid = 0; m_busy = 0; m_done = 0;
        fill_rom();
        test_reset();
        test_sequential();
        test_branch_back();
        test_forward_be();
        test_stall_branch();
        test_done_restart();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
